// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: pipeline register fields in, stall/flush/forward controls out.
interface pipe_hazard_ctrl_if;
  logic [4:0] rs1_D;
  logic [4:0] rs2_D;
  logic [4:0] rs1_E;
  logic [4:0] rs2_E;
  logic [4:0] rd_E;
  logic       memRead_E;
  logic       pc_src_E;
  logic [4:0] rd_M;
  logic       regWrite_M;
  logic       dmem_req_M;
  logic       dmem_ready;
  logic [4:0] rd_W;
  logic       regWrite_W;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushW;
  logic [1:0] fwdA_E;
  logic [1:0] fwdB_E;
  logic       mem_err;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, memRead_E, pc_src_E,
           rd_M, regWrite_M, dmem_req_M, dmem_ready, rd_W, regWrite_W,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           fwdA_E, fwdB_E, mem_err
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, memRead_E, pc_src_E,
           rd_M, regWrite_M, dmem_req_M, dmem_ready, rd_W, regWrite_W,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           fwdA_E, fwdB_E, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RV32I 5-stage hazard/forwarding controller with data-memory wait FSM.
// Optional HAZ_PERF_CNT_EN adds saturating stall_cycles/flush_events counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0]   flush_events
`endif
);

  typedef enum logic [1:0] {RUN, MEMWAIT, ABORT} state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_err;
  logic       mem_wait, load_use, eval_haz;

  function automatic logic [1:0] fwd_sel(input logic we_m, input logic [4:0] rd_m,
                                         input logic we_w, input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
    if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  // Mealy stall/flush/forward decode and next-state selection
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    mem_err    = 1'b0;
    eval_haz   = 1'b0;
    mem_wait   = hz.dmem_req_M && !hz.dmem_ready;
    load_use   = hz.memRead_E && (hz.rd_E != 5'd0) &&
                 ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
    fwd_a      = fwd_sel(hz.regWrite_M, hz.rd_M, hz.regWrite_W, hz.rd_W, hz.rs1_E);
    fwd_b      = fwd_sel(hz.regWrite_M, hz.rd_M, hz.regWrite_W, hz.rd_W, hz.rs2_E);

    case (state_q)
      RUN: begin
        if (mem_wait) begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
          state_d    = MEMWAIT;
          wait_cnt_d = 8'd1;
        end else begin
          eval_haz = 1'b1;
        end
      end
      MEMWAIT: begin
        if (hz.dmem_ready) begin
          eval_haz   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
          if (wait_cnt_q >= TIMEOUT) state_d = ABORT;
          else                       wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ABORT: begin
        mem_err    = 1'b1;
        flush_w    = 1'b1;
        eval_haz   = 1'b1;
        state_d    = RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Branch wins over load-use; both only when no memory stall is active
    if (eval_haz) begin
      if (hz.pc_src_E) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end

    if (!rst_n) begin
      {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err} = '0;
      fwd_a = '0;
      fwd_b = '0;
    end
  end

  assign hz.StallF  = stall_f;
  assign hz.StallD  = stall_d;
  assign hz.StallE  = stall_e;
  assign hz.StallM  = stall_m;
  assign hz.FlushD  = flush_d;
  assign hz.FlushE  = flush_e;
  assign hz.FlushW  = flush_w;
  assign hz.fwdA_E  = fwd_a;
  assign hz.fwdB_E  = fwd_b;
  assign hz.mem_err = mem_err;

  // State and wait counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_f && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_e && !(&flush_events)) flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;
  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hif();

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_events;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles (stall_cycles),
    .flush_events   (flush_events)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic       sF, sD, sE, sM, fD, fE, fW;
    logic [1:0] fa, fb;
    logic       me;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int unsigned m_wait = 0;   // stalled memory cycles in the current episode
  bit          m_abort = 1'b0;

  function automatic logic [1:0] fsel(input logic we_m, input logic [4:0] rdm,
                                      input logic we_w, input logic [4:0] rdw,
                                      input logic [4:0] rs);
    if (we_m && rdm != 5'd0 && rdm == rs) return 2'b10;
    if (we_w && rdw != 5'd0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t hz_eval(input exp_t e);
    exp_t r = e;
    if (hif.pc_src_E) begin
      r.fD = 1'b1; r.fE = 1'b1;
    end else if (hif.memRead_E && hif.rd_E != 5'd0 &&
                 (hif.rd_E == hif.rs1_D || hif.rd_E == hif.rs2_D)) begin
      r.sF = 1'b1; r.sD = 1'b1; r.fE = 1'b1;
    end
    return r;
  endfunction

  task automatic idle();
    rst_n = 1'b1;
    hif.rs1_D = '0; hif.rs2_D = '0; hif.rs1_E = '0; hif.rs2_E = '0; hif.rd_E = '0;
    hif.memRead_E = 1'b0; hif.pc_src_E = 1'b0;
    hif.rd_M = '0; hif.regWrite_M = 1'b0; hif.dmem_req_M = 1'b0; hif.dmem_ready = 1'b0;
    hif.rd_W = '0; hif.regWrite_W = 1'b0;
  endtask

  // Compute expected response for the currently driven inputs, then advance a cycle
  task automatic step();
    exp_t e;
    bit   stall_now;
    e = '0;
    e.rst = !rst_n;
    if (!rst_n) begin
      m_wait  = 0;
      m_abort = 1'b0;
    end else begin
      e.fa = fsel(hif.regWrite_M, hif.rd_M, hif.regWrite_W, hif.rd_W, hif.rs1_E);
      e.fb = fsel(hif.regWrite_M, hif.rd_M, hif.regWrite_W, hif.rd_W, hif.rs2_E);
      stall_now = (m_wait == 0) ? (hif.dmem_req_M && !hif.dmem_ready) : !hif.dmem_ready;
      if (m_abort) begin
        e.me = 1'b1; e.fW = 1'b1;
        e = hz_eval(e);
        m_abort = 1'b0; m_wait = 0;
      end else if (stall_now) begin
        {e.sF, e.sD, e.sE, e.sM, e.fW} = '1;
        if (m_wait == T) begin
          m_abort = 1'b1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end else begin
        e = hz_eval(e);
        m_wait = 0;
      end
    end
    q.push_back(e);
    @(posedge clk); #1;
    cyc++;
  endtask

`ifdef HAZ_PERF_CNT_EN
  int unsigned sc = 0, fc = 0;
`endif

  // Monitor: pop expected response and compare mid-cycle
  always @(negedge clk) begin : mon
    exp_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {e.rst, hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD,
           hif.FlushE, hif.FlushW, hif.fwdA_E, hif.fwdB_E, hif.mem_err};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs cyc %0d got sF/sD/sE/sM/fD/fE/fW/fa/fb/me=%b exp %b",
                 cyc, g[11:0], e[11:0]);
      end
`ifdef HAZ_PERF_CNT_EN
      checks++;
      if (stall_cycles !== 16'(sc) || flush_events !== 16'(fc)) begin
        errors++;
        $display("FAIL counters cyc %0d got %0d/%0d exp %0d/%0d",
                 cyc, stall_cycles, flush_events, sc, fc);
      end
      if (e.rst) begin
        sc = 0; fc = 0;
      end else begin
        if (e.sF && sc < 16'hFFFF) sc++;
        if (e.fE && fc < 16'hFFFF) fc++;
      end
`endif
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    // reset forces outputs low even with a forwarding match present
    hif.rs1_E = 5'd5; hif.rd_M = 5'd5; hif.regWrite_M = 1'b1;
    step();
    step();

    // forwarding priority
    idle();
    hif.rs1_E = 5'd5; hif.rd_M = 5'd5; hif.regWrite_M = 1'b1;
    hif.rd_W = 5'd5; hif.regWrite_W = 1'b1; hif.rs2_E = 5'd5;
    step();
    hif.regWrite_M = 1'b0; step();
    hif.rd_M = 5'd0; hif.rd_W = 5'd0; step();

    // load-use, then rd_E=0
    idle();
    hif.memRead_E = 1'b1; hif.rd_E = 5'd3; hif.rs2_D = 5'd3; step();
    hif.rd_E = 5'd0; step();
    // branch vs load-use
    hif.rd_E = 5'd3; hif.pc_src_E = 1'b1; step();
    idle(); step();

    // memory wait: 3 low cycles then ready
    hif.dmem_req_M = 1'b1;
    repeat (3) step();
    hif.dmem_ready = 1'b1; step();
    idle(); step();

    // timeout: 5 stalled cycles, abort, then run
    hif.dmem_req_M = 1'b1;
    repeat (5) step();
    step();
    hif.dmem_req_M = 1'b0; step();
    step();

    // reset during second wait cycle
    hif.dmem_req_M = 1'b1; step();
    rst_n = 1'b0; step();
    idle(); step(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      hif.rs1_D      = 5'($urandom_range(0, 3));
      hif.rs2_D      = 5'($urandom_range(0, 3));
      hif.rs1_E      = 5'($urandom_range(0, 3));
      hif.rs2_E      = 5'($urandom_range(0, 3));
      hif.rd_E       = 5'($urandom_range(0, 3));
      hif.rd_M       = 5'($urandom_range(0, 3));
      hif.rd_W       = 5'($urandom_range(0, 3));
      hif.memRead_E  = 1'($urandom_range(0, 1));
      hif.pc_src_E   = ($urandom_range(0, 3) == 0);
      hif.regWrite_M = 1'($urandom_range(0, 1));
      hif.regWrite_W = 1'($urandom_range(0, 1));
      hif.dmem_req_M = ($urandom_range(0, 2) == 0);
      hif.dmem_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    idle();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and forwarding controller for the RV32I 5-stage pipeline. It reads the decode-stage and EX-stage register fields (rs1/rs2/rd, memRead, regWrite) and produces the stall and flush controls that drive the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also produces the EX-stage operand forwarding selects. It tracks multi-cycle data-memory waits with an FSM and a timeout counter.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEMWAIT cycles without dmem_ready before abort (range 1..255)
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
rs1_D  in  5  decode source reg 1
rs2_D  in  5  decode source reg 2
rs1_E  in  5  EX source reg 1
rs2_E  in  5  EX source reg 2
rd_E  in  5  EX destination
memRead_E  in  1  EX instruction is a load
pc_src_E  in  1  branch taken / jump resolved in EX
rd_M  in  5  MEM destination
regWrite_M  in  1  MEM writes RF
dmem_req_M  in  1  MEM-stage data memory access active
dmem_ready  in  1  data memory completes access this cycle
rd_W  in  5  WB destination
regWrite_W  in  1  WB writes RF
StallF, StallD, StallE, StallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
FlushD, FlushE, FlushW  out  1  clear IF-ID / ID-EX / MEM-WB next edge
fwdA_E, fwdB_E  out  2  operand select: 00 RF, 01 WB result, 10 MEM ALU result
mem_err  out  1  one-cycle pulse: memory access aborted on timeout

Behaviour:
- Reset is synchronous, active-low on clk: state=RUN, wait_cnt=0. While rst_n=0, all stall/flush/fwd/mem_err outputs are forced 0.
- States:
  - RUN: normal operation.
  - MEMWAIT: MEM-stage access pending.
  - ABORT: single cycle after a timeout.
- Stall/flush outputs are Mealy (combinational from state + inputs) and act on the same cycle. The state and wait_cnt are registered.
- Forwarding, evaluated in all states:
  - fwdA_E=10 if regWrite_M && rd_M!=0 && rd_M==rs1_E.
  - Otherwise fwdA_E=01 if regWrite_W && rd_W!=0 && rd_W==rs1_E.
  - Otherwise fwdA_E=00.
  - MEM has priority over WB. fwdB_E is identical using rs2_E.
- mem_wait = dmem_req_M && !dmem_ready.
- RUN with mem_wait=1:
  - StallF=StallD=StallE=StallM=1, FlushW=1 (bubble into WB).
  - Next state MEMWAIT, wait_cnt<=1.
  - Load-use and branch flush are suppressed this cycle.
- RUN with mem_wait=0, branch (pc_src_E=1): FlushD=1, FlushE=1. Branch has priority over load-use; load-use stall is not asserted.
- RUN with mem_wait=0, load-use (memRead_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D)): StallF=StallD=1, FlushE=1.
- RUN otherwise: all outputs 0.
- MEMWAIT, dmem_ready=1: all stalls 0 this cycle; branch/load-use are evaluated as in RUN; next state RUN, wait_cnt<=0.
- MEMWAIT, dmem_ready=0 and wait_cnt<MEM_TIMEOUT: stalls F/D/E/M=1, FlushW=1, wait_cnt++.
- MEMWAIT, dmem_ready=0 and wait_cnt==MEM_TIMEOUT: stalls F/D/E/M=1, FlushW=1; next state ABORT.
- ABORT:
  - mem_err=1, FlushW=1 (squashes the aborted instruction's writeback), all stalls 0.
  - Branch/load-use are evaluated as in RUN; next state RUN, wait_cnt<=0.
  - dmem_req_M is ignored in this cycle.
- pc_src_E held during MEMWAIT is not acted on until the cycle stalls release.
- Reset asserted in MEMWAIT/ABORT returns to RUN at the next edge with no mem_err pulse.

Optional Feature:
HAZ_PERF_CNT_EN: when defined, adds outputs stall_cycles[CNT_W-1:0] and flush_events[CNT_W-1:0], both reset to 0 and saturating at all-ones.
- stall_cycles increments each cycle StallF=1.
- flush_events increments each cycle FlushE=1.
- When the macro is undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forwarding: rs1_E=5, rd_M=5, regWrite_M=1, rd_W=5, regWrite_W=1 -> fwdA_E=10. Then regWrite_M=0 -> fwdA_E=01. Then rd_M=rd_W=0 -> 00.
- Load-use: memRead_E=1, rd_E=3, rs2_D=3, pc_src_E=0 -> StallF=StallD=FlushE=1 for exactly that cycle. With rd_E=0 -> all 0.
- Branch vs load-use collision: load-use condition plus pc_src_E=1 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait:
  - dmem_req_M=1, dmem_ready low for 3 cycles, then high -> stalls F/D/E/M and FlushW high 3 cycles, 0 on the ready cycle.
  - mem_err never asserts.
- Timeout (MEM_TIMEOUT=4): dmem_ready held 0 ->
  - stalls high 5 cycles;
  - then one cycle with mem_err=1, FlushW=1 and stalls 0;
  - then RUN with no stalls if dmem_req_M drops.
- Reset mid-wait: rst_n=0 in the 2nd MEMWAIT cycle -> all outputs 0 immediately. After release, RUN, and mem_err stays 0. With HAZ_PERF_CNT_EN defined, counters read 0.
